// File: rtl/qdec_pkg.sv
// qdec_pkg: mode encodings, Gray states, SYNC range and helpers for quad_decoder_mc
package qdec_pkg;
  typedef enum logic [1:0] {
    QDEC_MODE_1X  = 2'b00,
    QDEC_MODE_2X  = 2'b01,
    QDEC_MODE_4X  = 2'b10,
    QDEC_MODE_4XB = 2'b11
  } qdec_mode_e;
  localparam logic [1:0] QDEC_S0 = 2'b00;
  localparam logic [1:0] QDEC_S1 = 2'b10;
  localparam logic [1:0] QDEC_S2 = 2'b11;
  localparam logic [1:0] QDEC_S3 = 2'b01;
  localparam int QDEC_SYNC_MIN = 2;
  localparam int QDEC_SYNC_MAX = 4;
  function automatic int qdec_sync_clamp(input int s);
    return s < QDEC_SYNC_MIN ? QDEC_SYNC_MIN : s > QDEC_SYNC_MAX ? QDEC_SYNC_MAX : s;
  endfunction
  function automatic logic [1:0] qdec_fwd(input logic [1:0] p);
    return p == QDEC_S0 ? QDEC_S1 : p == QDEC_S1 ? QDEC_S2 : p == QDEC_S2 ? QDEC_S3 : QDEC_S0;
  endfunction
endpackage

// File: rtl/qdec_filter.sv
// qdec_filter: SYNC-stage synchroniser + stability filter (d_i async in, len_i stability length, load_i bypasses filter, q_o filtered)
module qdec_filter
  import qdec_pkg::*;
#(
  parameter int SYNC = 2,
  parameter int FW   = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          d_i,
  input  logic [FW-1:0] len_i,
  input  logic          load_i,
  output logic          q_o
);
  localparam int SN = qdec_sync_clamp(SYNC);
  logic [SN-1:0] sync_q;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          flt_q, flt_d, s;
  always_comb begin
    s = sync_q[SN-1];
    flt_d = (load_i || (s != flt_q && cnt_q >= len_i)) ? s : flt_q;
    cnt_d = (load_i || s == flt_q || cnt_q >= len_i) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      flt_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SN-2:0], d_i};
      cnt_q  <= cnt_d;
      flt_q  <= flt_d;
    end
  assign q_o = flt_q;
endmodule

// File: rtl/quad_decoder_mc.sv
// quad_decoder_mc: filtered quadrature decoder, 1x/2x/4x up/down counter with clr/preset, sticky err, optional index capture (QDEC_INDEX_EN)
module quad_decoder_mc
  import qdec_pkg::*;
#(
  parameter int CW   = 32,
  parameter int SYNC = 2,
  parameter int FW   = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          quadA_i,
  input  logic          quadB_i,
  input  logic          index_i,
  input  logic [1:0]    mode_i,
  input  logic          dir_inv_i,
  input  logic [FW-1:0] flt_len_i,
  input  logic          clr_i,
  input  logic          preset_i,
  input  logic [CW-1:0] preset_val_i,
  input  logic          err_clr_i,
  output logic [CW-1:0] count_o,
  output logic          dir_o,
  output logic          step_o,
  output logic          err_o,
  output logic [CW-1:0] idx_latch_o,
  output logic          idx_vld_o
);
  localparam int SN = qdec_sync_clamp(SYNC);
  localparam logic [2:0] PRIME_END = 3'(SN + 2);
  logic          a_f, b_f, primed, chg, illegal, up, cnt_en;
  logic [1:0]    s, prv_q;
  logic [2:0]    pcnt_q, pcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d, step_q, step_d, err_q, err_d;
  qdec_filter #(.SYNC(SYNC), .FW(FW)) u_fa (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(quadA_i), .len_i(flt_len_i), .load_i(!primed), .q_o(a_f)
  );
  qdec_filter #(.SYNC(SYNC), .FW(FW)) u_fb (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(quadB_i), .len_i(flt_len_i), .load_i(!primed), .q_o(b_f)
  );
  always_comb begin
    s       = {a_f, b_f};
    primed  = pcnt_q == PRIME_END;
    pcnt_d  = primed ? pcnt_q : pcnt_q + 3'd1;
    chg     = primed && s != prv_q;
    illegal = chg && s == ~prv_q;
    up      = (s == qdec_fwd(prv_q)) ^ dir_inv_i;
    cnt_en  = chg && !illegal && (mode_i == QDEC_MODE_1X ?
                (prv_q == QDEC_S0 && s == QDEC_S1) || (prv_q == QDEC_S1 && s == QDEC_S0) :
              mode_i == QDEC_MODE_2X ? s[1] != prv_q[1] : 1'b1);
    step_d  = cnt_en && !clr_i && !preset_i;
    cnt_d   = clr_i ? '0 : preset_i ? preset_val_i :
              step_d ? (up ? cnt_q + 1'b1 : cnt_q - 1'b1) : cnt_q;
    dir_d   = step_d ? up : dir_q;
    err_d   = illegal | (err_q & ~err_clr_i);
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      pcnt_q <= '0;
      prv_q  <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      prv_q  <= s;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      err_q  <= err_d;
    end
  assign count_o = cnt_q;
  assign dir_o   = dir_q;
  assign step_o  = step_q;
  assign err_o   = err_q;
`ifdef QDEC_INDEX_EN
  logic          i_f, iprv_q, ivld_q, rise;
  logic [CW-1:0] ilat_q;
  qdec_filter #(.SYNC(SYNC), .FW(FW)) u_fi (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(index_i), .len_i(flt_len_i), .load_i(!primed), .q_o(i_f)
  );
  assign rise = primed && i_f && !iprv_q;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      iprv_q <= 1'b0;
      ivld_q <= 1'b0;
      ilat_q <= '0;
    end else begin
      iprv_q <= i_f;
      ivld_q <= rise;
      ilat_q <= rise ? cnt_q : ilat_q;
    end
  assign idx_latch_o = ilat_q;
  assign idx_vld_o   = ivld_q;
`else
  logic unused_idx;
  assign unused_idx  = index_i;
  assign idx_latch_o = '0;
  assign idx_vld_o   = 1'b0;
`endif
endmodule

// File: tb/tb_quad_decoder_mc.sv
// tb_quad_decoder_mc: directed self-checking bench for quad_decoder_mc
module tb_quad_decoder_mc;
  localparam int CW = 32, SYNC = 2, FW = 4;
  logic          clk = 1'b0, rstn = 1'b0;
  logic          qa = 1'b0, qb = 1'b0, idx = 1'b0;
  logic [1:0]    mode = 2'b10;
  logic          dir_inv = 1'b0, clr = 1'b0, preset = 1'b0, err_clr = 1'b0;
  logic [FW-1:0] flt_len = '0;
  logic [CW-1:0] preset_val = '0;
  logic [CW-1:0] count, idx_latch;
  logic          dir, step, err, idx_vld;
  int            n_cmp = 0, n_err = 0, step_cnt = 0, sc0;
  quad_decoder_mc #(.CW(CW), .SYNC(SYNC), .FW(FW)) dut (
    .clk_i(clk), .rstn_i(rstn), .quadA_i(qa), .quadB_i(qb), .index_i(idx),
    .mode_i(mode), .dir_inv_i(dir_inv), .flt_len_i(flt_len), .clr_i(clr),
    .preset_i(preset), .preset_val_i(preset_val), .err_clr_i(err_clr),
    .count_o(count), .dir_o(dir), .step_o(step), .err_o(err),
    .idx_latch_o(idx_latch), .idx_vld_o(idx_vld)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (step) step_cnt <= step_cnt + 1;
  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic edge_ab(input logic [1:0] v);
    {qa, qb} = v;
    tick(10);
  endtask
  task automatic fwd_cycle();
    edge_ab(2'b10); edge_ab(2'b11); edge_ab(2'b01); edge_ab(2'b00);
  endtask
  task automatic rev_cycle();
    edge_ab(2'b01); edge_ab(2'b11); edge_ab(2'b10); edge_ab(2'b00);
  endtask
  task automatic pulse_clr();
    clr = 1'b1; tick(1); clr = 1'b0;
  endtask
  initial begin
    tick(3);
    chk("rst_count", count, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_idx_latch", idx_latch, 0);
    chk("rst_idx_vld", 32'(idx_vld), 0);
    rstn = 1'b1;
    tick(20);
    sc0 = step_cnt;
    {qa, qb} = 2'b10;
    tick(SYNC + 1);
    chk("lat_before", count, 0);
    tick(1);
    chk("lat_at", count, 1);
    chk("lat_step", 32'(step), 1);
    tick(6);
    edge_ab(2'b11); edge_ab(2'b01); edge_ab(2'b00);
    fwd_cycle();
    chk("fwd8_count", count, 8);
    chk("fwd8_steps", 32'(step_cnt - sc0), 8);
    chk("fwd8_dir", 32'(dir), 1);
    pulse_clr();
    chk("clr", count, 0);
    mode = 2'b00;
    repeat (4) fwd_cycle();
    repeat (2) rev_cycle();
    chk("1x_count", count, 2);
    chk("1x_dir", 32'(dir), 0);
    pulse_clr();
    mode = 2'b01;
    repeat (4) fwd_cycle();
    repeat (2) rev_cycle();
    chk("2x_count", count, 4);
    pulse_clr();
    mode = 2'b10;
    edge_ab(2'b01);
    chk("wrap_down", count, 32'hFFFF_FFFF);
    chk("wrap_dir", 32'(dir), 0);
    preset_val = 32'h7FFF_FFFF;
    preset = 1'b1; tick(1); preset = 1'b0;
    chk("preset", count, 32'h7FFF_FFFF);
    edge_ab(2'b00);
    chk("wrap_up", count, 32'h8000_0000);
    edge_ab(2'b11);
    chk("illegal_err", 32'(err), 1);
    chk("illegal_count", count, 32'h8000_0000);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("err_clr", 32'(err), 0);
    {qa, qb} = 2'b00;
    tick(SYNC + 1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("err_set_wins", 32'(err), 1);
    tick(8);
    chk("illegal2_count", count, 32'h8000_0000);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    pulse_clr();
    flt_len = 4'd3;
    qa = 1'b1; tick(2); qa = 1'b0; tick(15);
    chk("glitch_count", count, 0);
    chk("glitch_err", 32'(err), 0);
    qa = 1'b1; tick(5); qa = 1'b0;
    tick(SYNC - 1);
    chk("flt_before", count, 0);
    tick(1);
    chk("flt_at", count, 1);
    tick(20);
    chk("flt_back", count, 0);
    flt_len = '0;
    tick(5);
    preset_val = 32'd100;
    preset = 1'b1; tick(1); preset = 1'b0;
    qa = 1'b1; idx = 1'b1;
    tick(SYNC + 2);
    chk("idx_count", count, 101);
`ifdef QDEC_INDEX_EN
    chk("idx_latch", idx_latch, 100);
    chk("idx_vld_hi", 32'(idx_vld), 1);
    tick(1);
    chk("idx_vld_lo", 32'(idx_vld), 0);
`else
    chk("idx_latch_off", idx_latch, 0);
    chk("idx_vld_off", 32'(idx_vld), 0);
    tick(1);
`endif
    idx = 1'b0;
    tick(10);
    edge_ab(2'b11);
    chk("pre_rst_count", count, 102);
    rstn = 1'b0;
    tick(3);
    chk("mid_rst_count", count, 0);
    rstn = 1'b1;
    sc0 = step_cnt;
    tick(30);
    chk("rerst_count", count, 0);
    chk("rerst_err", 32'(err), 0);
    chk("rerst_steps", 32'(step_cnt - sc0), 0);
    edge_ab(2'b01);
    chk("rerst_fwd", count, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/quad_decoder_mc.md
Name: quad_decoder_mc

Overview:
- Second-generation quadrature decoder: synchronises and glitch-filters encoder A/B inputs, then drives an up/down position counter.
- Adds over the first generation: parametrised count width, run-time 1x/2x/4x mode, illegal-transition detection, clear/preset, and optional index capture.
- Sits between the extension-connector encoder pins and the housekeeping register bank; count_o is read by the PS.

Parameters:
- CW, 32: position counter width (two's complement, wraps).
- SYNC, 2: synchroniser flop stages per input, legal range 2..4.
- FW, 4: filter length field width.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- quadA_i  in  1  encoder A, asynchronous
- quadB_i  in  1  encoder B, asynchronous
- index_i  in  1  encoder index, asynchronous
- mode_i  in  2  00=1x, 01=2x, 10=4x, 11=4x
- dir_inv_i  in  1  swaps the counting sense
- flt_len_i  in  FW  filter stability length
- clr_i  in  1  synchronous counter clear
- preset_i  in  1  synchronous counter load
- preset_val_i  in  CW  load value
- err_clr_i  in  1  clears err_o
- count_o  out  CW  position
- dir_o  out  1  direction of the last counted step, 1=up
- step_o  out  1  one-cycle pulse per counted step
- err_o  out  1  sticky illegal-transition flag
- idx_latch_o  out  CW  count captured at index
- idx_vld_o  out  1  one-cycle pulse on index capture

Behaviour:
- Reset: all outputs and internal registers are 0; the primed flag is cleared.
- Synchroniser: each input passes through SYNC flops.
- Filter:
  - Per input, the filtered value takes the synchronised value after it differs from the filtered value for flt_len_i+1 consecutive cycles.
  - The stability counter zeroes whenever synced equals filtered.
  - flt_len_i=0 gives a single-cycle delay.
  - A change to flt_len_i takes effect on the next cycle.
- Priming: the first cycle after reset copies filtered {A,B} into the previous-state register without counting or flagging an error.
- Decode: compare filtered state S={A,B} against previous state P every cycle.
  - Forward Gray sequence: 00→10→11→01→00. The reverse sequence counts down.
  - dir_inv_i inverts the counting sense.
  - 4x: every legal transition counts.
  - 2x: only transitions where A changes count.
  - 1x: only 00→10 (up) and 10→00 (down) count, so a back-and-forth cancels.
  - Illegal transition (both bits change): err_o←1, no count, P←S.
  - err_clr_i clears err_o; if set and clear occur in the same cycle, set wins.
- Counter update priority: clr_i > preset_i > step.
  - A suppressed step still produces no step_o.
  - Arithmetic is modulo 2^CW: 0−1 = all ones, max+1 = 0.
- Latency: with flt_len_i=L, count_o changes SYNC+L+2 cycles after an edge first appears at the first synchroniser flop. step_o and dir_o are registered alongside count_o.
- Reset mid-operation: all state is discarded and the block re-primes, so no spurious count or error occurs.

Optional Feature:
- Macro: QDEC_INDEX_EN.
- Defined:
  - index_i is synchronised and filtered like A/B.
  - On a filtered rising edge, idx_latch_o takes count_o as it was before any same-cycle update, and idx_vld_o pulses for one cycle.
- Undefined:
  - index_i is ignored.
  - idx_latch_o=0 and idx_vld_o=0 constantly.
  - No index logic is synthesised.

Decomposition:
- Package qdec_pkg:
  - mode encodings QDEC_MODE_1X/2X/4X;
  - Gray state constants;
  - the SYNC legal-range constants.
- Sub-module qdec_filter: one input's synchroniser plus stability filter, parametrised by SYNC and FW. Instantiated for A, B, and index (index only under QDEC_INDEX_EN).

Test Plan:
- 4x, flt_len_i=0, 8 forward Gray edges spaced 10 cycles apart → count_o=8, 8 step_o pulses, dir_o=1; first change SYNC+2 cycles after the first edge.
- Mode 1x, 4 full forward cycles then 2 full reverse cycles → count_o=2; 2x with the same stimulus → count_o=4.
- From count 0, 4x, one reverse edge → count_o=2^CW−1. Then preset_i with 0x7FFFFFFF and one forward edge → 0x80000000.
- Simultaneous A and B toggle → err_o=1, count unchanged. err_clr_i asserted in the same cycle as a new illegal edge → err_o stays 1.
- flt_len_i=3, 2-cycle glitch on A → no count. 5-cycle pulse → one count at SYNC+5 latency.
- QDEC_INDEX_EN: index rising edge with count_o=100 while a forward step lands in the same cycle → idx_latch_o=100, count_o=101, idx_vld_o pulses once. Reset asserted mid-sequence with inputs at 11 → after release, no error and no count.
